simplez_io: RTL and testbench
=============================

SIMPLEZ_IO -- requirements
Module: simplez_io

Interface
REQ-001 The block SHALL be parameterised with DATAW: default 12; data bus width.
REQ-002 The block SHALL be parameterised with ADDRW: default 9; address bus width.
REQ-003 The block SHALL be parameterised with TXDEPTH: default 4; screen FIFO depth in entries, power of two, minimum 2.
REQ-004 The block SHALL have port clk: input, 1 bit; the only clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rstn: input, 1 bit; asynchronous, active-low reset.
REQ-006 The block SHALL have port addr: input, ADDRW bits; CPU address bus.
REQ-007 The block SHALL have port rd: input, 1 bit; CPU read strobe, valid one cycle.
REQ-008 The block SHALL have port wr: input, 1 bit; CPU write strobe, valid one cycle.
REQ-009 The block SHALL have port data_in: input, DATAW bits; CPU write data.
REQ-010 The block SHALL have port data_out: output, DATAW bits; registered read data.
REQ-011 The block SHALL have port tx_data: output, 8 bits; screen byte at the FIFO head.
REQ-012 The block SHALL have port tx_valid: output, 1 bit; screen byte available.
REQ-013 The block SHALL have port tx_ready: input, 1 bit; screen sink accepts the byte.
REQ-014 The block SHALL have port rx_data: input, 8 bits; keyboard byte.
REQ-015 The block SHALL have port rx_valid: input, 1 bit; keyboard byte offered.
REQ-016 The block SHALL have port rx_ready: output, 1 bit; keyboard holding register empty.

Function
REQ-017 The block SHALL decode four registers: 508 = screen status, 509 = screen data, 510 = keyboard status, 511 = keyboard data; every other address SHALL be ignored.
REQ-018 A read is rd=1 with a decoded address; on the next rising edge data_out SHALL take the register value (one-cycle latency); for a non-decoded address or rd=0, data_out SHALL be 0 so it can be ORed with memory.
REQ-019 The screen status register SHALL read as: bit0 = FIFO not full, bit1 = sticky overflow, all other bits 0.
REQ-020 The keyboard status register SHALL read as: bit0 = keyboard full, all other bits 0.
REQ-021 The keyboard data register SHALL read as {DATAW-8 zeros, held byte}; a read of the screen data register SHALL return 0.
REQ-022 wr to 509 SHALL push data_in[7:0] into the FIFO when it is not full, or when it is full and a pop occurs in the same cycle.
REQ-023 Otherwise, wr to 509 SHALL drop the byte and set overflow.
REQ-024 wr to 508 SHALL clear overflow unless an overflowing push occurs in the same cycle, in which case set wins.
REQ-025 wr to 510 or 511 SHALL have no effect.
REQ-026 tx_valid SHALL equal FIFO not empty, and tx_data SHALL be the head entry; tx_data SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-027 A pop SHALL occur when tx_valid=1 and tx_ready=1; FIFO order SHALL be preserved.
REQ-028 Read and write pointers SHALL wrap modulo TXDEPTH; the count SHALL range over 0..TXDEPTH.
REQ-029 rx_ready SHALL equal NOT keyboard-full.
REQ-030 rx_valid=1 with rx_ready=1 SHALL capture rx_data and set keyboard-full on the same edge.
REQ-031 A read of 511 while keyboard-full=1 SHALL return the byte and clear keyboard-full on the same edge.
REQ-032 A read of 511 while keyboard-full=0 SHALL return the last byte and change no state.
REQ-033 A capture and a clear cannot coincide, since a capture requires full=0; the block SHALL keep no extra keyboard buffering.
REQ-034 With rd=1 and wr=1 in the same cycle, the write SHALL take effect and data_out SHALL reflect the pre-write state.

Reset
REQ-035 rstn=0 SHALL asynchronously clear FIFO pointers and count, overflow, keyboard-full, held byte and data_out.
REQ-036 While rstn=0, tx_valid SHALL be 0 and rx_ready SHALL be forced to 0.
REQ-037 rx_ready SHALL be 1 from the first edge after rstn rises.
REQ-038 Reset asserted mid-transfer SHALL discard all queued bytes.

Verification
REQ-039 The bench SHALL cover: with tx_ready=0, write 0x41, 0x42, 0x43, 0x44 to 509, then read 508 -> data_out=0x000 (full); then a fifth write of 0x45 followed by a read of 508 -> 0x002.
REQ-040 The bench SHALL cover: tx_ready=1 after the previous scenario -> tx_data 0x41, 0x42, 0x43, 0x44 on consecutive cycles, then tx_valid=0; 0x45 is never emitted.
REQ-041 The bench SHALL cover: with the FIFO full and tx_ready=1, write 0x55 to 509 -> accepted with no overflow; 0x55 emitted fifth.
REQ-042 The bench SHALL cover: rx_valid=1 with rx_data=0x7A -> rx_ready drops; read 510 -> 0x001; read 511 -> 0x07A; next read of 510 -> 0x000; rx_ready=1.
REQ-043 The bench SHALL cover: a read of address 100 -> data_out=0; wr to 510 with 0xFFF -> no state change.
REQ-044 The bench SHALL cover: two bytes queued and keyboard full, then rstn pulsed low mid-cycle -> tx_valid=0 immediately, and after release reads of 508, 510 and 511 return 0x001, 0x000 and 0x000.

Source files
------------

// File: rtl/simplez_io.sv
// Memory-mapped screen/keyboard port for the Simplez CPU: a small byte FIFO
// toward the screen and a single-byte keyboard holding register.
module simplez_io #(
    parameter int DATAW   = 12,
    parameter int ADDRW   = 9,
    parameter int TXDEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [ADDRW-1:0] addr,
    input  logic             rd,
    input  logic             wr,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready
);

    localparam int PTRW = $clog2(TXDEPTH);

    localparam logic [ADDRW-1:0] A_SCR_ST   = ADDRW'(508);
    localparam logic [ADDRW-1:0] A_SCR_DATA = ADDRW'(509);
    localparam logic [ADDRW-1:0] A_KBD_ST   = ADDRW'(510);
    localparam logic [ADDRW-1:0] A_KBD_DATA = ADDRW'(511);

    logic [7:0]       fifo_mem [TXDEPTH];
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW:0]    count;
    logic             overflow;
    logic             kbd_full;
    logic [7:0]       kbd_byte;
    logic             rx_en;

    logic             fifo_full;
    logic             pop;
    logic             push_req;
    logic             push;
    logic             ovf_set;
    logic             ovf_clr;
    logic             capture;
    logic             kbd_clr;
    logic [DATAW-1:0] rd_val;
    logic             unused_data_hi;

    assign unused_data_hi = ^data_in[DATAW-1:8];

    assign fifo_full = (count == (PTRW+1)'(TXDEPTH));
    assign tx_valid  = (count != '0);
    assign tx_data   = fifo_mem[rd_ptr];
    assign pop       = tx_valid & tx_ready;

    // A write into a full FIFO is still accepted when the head leaves this cycle.
    assign push_req  = wr & (addr == A_SCR_DATA);
    assign push      = push_req & (~fifo_full | pop);
    assign ovf_set   = push_req & ~push;
    assign ovf_clr   = wr & (addr == A_SCR_ST);

    // rx_en holds the keyboard closed until the first edge after reset releases.
    assign rx_ready  = rx_en & ~kbd_full;
    assign capture   = rx_valid & rx_ready;
    assign kbd_clr   = rd & (addr == A_KBD_DATA) & kbd_full;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        rd_val = '0;
        if (rd) begin
            case (addr)
                A_SCR_ST:   rd_val = DATAW'({overflow, ~fifo_full});
                A_KBD_ST:   rd_val = DATAW'(kbd_full);
                A_KBD_DATA: rd_val = DATAW'(kbd_byte);
                default:    rd_val = '0;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= data_in[7:0];
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            kbd_full <= 1'b0;
            kbd_byte <= '0;
            rx_en    <= 1'b0;
            data_out <= '0;
        end else begin
            rx_en    <= 1'b1;
            data_out <= rd_val;

            if (push) wr_ptr <= wr_ptr + PTRW'(1);
            if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTRW+1)'(1);
                2'b01:   count <= count - (PTRW+1)'(1);
                default: count <= count;
            endcase

            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;

            if (kbd_clr) begin
                kbd_full <= 1'b0;
            end else if (capture) begin
                kbd_full <= 1'b1;
                kbd_byte <= rx_data;
            end
        end
    end

endmodule

// File: tb/tb_simplez_io.sv
// Scoreboard bench for simplez_io: a queue-based reference model predicts reads
// and screen bytes; a negedge monitor compares whatever the DUT presents.
module tb_simplez_io;

    localparam int DATAW   = 12;
    localparam int ADDRW   = 9;
    localparam int TXDEPTH = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic [ADDRW-1:0] addr = '0;
    logic             rd = 1'b0;
    logic             wr = 1'b0;
    logic [DATAW-1:0] data_in = '0;
    logic [DATAW-1:0] data_out;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
    logic [7:0]       rx_data = '0;
    logic             rx_valid = 1'b0;
    logic             rx_ready;

    simplez_io #(.DATAW(DATAW), .ADDRW(ADDRW), .TXDEPTH(TXDEPTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .addr     (addr),
        .rd       (rd),
        .wr       (wr),
        .data_in  (data_in),
        .data_out (data_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    initial forever #10 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [8:0] a;
        logic [11:0] val;
    } dout_t;

    dout_t      dout_q[$];
    logic [7:0] tx_exp[$];
    bit         ovf_m;
    bit         kfull_m;
    bit         ready_ok_m;
    logic [7:0] kbyte_m;
    int         n_vec = 0;
    int         n_mis = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: read data lands one edge after the request; screen bytes are
    // compared to the model head whenever offered and popped on handshake.
    always @(negedge clk) begin : monitor
        dout_t e;
        if (rstn === 1'b1) begin
            while (dout_q.size() > 0 && dout_q[0].cyc < cyc) begin
                e = dout_q.pop_front();
                check($sformatf("data_out_rd%0d", e.a), 32'(data_out), 32'(e.val));
            end
            if (tx_valid) begin
                if (tx_exp.size() == 0) begin
                    n_vec++;
                    n_mis++;
                    $display("FAIL tx_unexpected: got byte 0x%0h, expected none", tx_data);
                end else begin
                    check("tx_data", 32'(tx_data), 32'(tx_exp[0]));
                    if (tx_ready) void'(tx_exp.pop_front());
                end
            end
        end
    end

    // One bus cycle: drive inputs, then advance the model from its pre-edge state.
    // want >= 0 replaces the model's predicted read value with a fixed constant.
    task automatic step(input logic r, input logic w, input logic [8:0] a,
                        input logic [11:0] d, input logic txr, input logic rxv,
                        input logic [7:0] rxd, input int want);
        bit pop_m, full_m, ovf_set_m, rxr_m;
        logic [11:0] ev;
        dout_t e;
        @(posedge clk);
        #1;
        ready_ok_m = 1'b1;
        rd = r; wr = w; addr = a; data_in = d;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;

        rxr_m = ready_ok_m && !kfull_m;
        check("rx_ready", 32'(rx_ready), 32'(rxr_m));

        pop_m  = txr && (tx_exp.size() != 0);
        full_m = (tx_exp.size() == TXDEPTH);

        ev = '0;
        if (r) begin
            case (a)
                9'd508:  ev = {10'd0, ovf_m, !full_m};
                9'd510:  ev = {11'd0, kfull_m};
                9'd511:  ev = {4'd0, kbyte_m};
                default: ev = '0;
            endcase
        end
        if (want >= 0) ev = want[11:0];
        e.cyc = cyc; e.a = a; e.val = ev;
        dout_q.push_back(e);

        ovf_set_m = 1'b0;
        if (w && a == 9'd509) begin
            if (!full_m || pop_m) tx_exp.push_back(d[7:0]);
            else ovf_set_m = 1'b1;
        end
        if (ovf_set_m) ovf_m = 1'b1;
        else if (w && a == 9'd508) ovf_m = 1'b0;

        if (r && a == 9'd511 && kfull_m) begin
            kfull_m = 1'b0;
        end else if (rxv && rxr_m) begin
            kbyte_m = rxd;
            kfull_m = 1'b1;
        end
    endtask

    task automatic idle(input logic txr);
        step(1'b0, 1'b0, 9'd0, 12'd0, txr, 1'b0, 8'd0, -1);
    endtask

    task automatic rd_reg(input logic [8:0] a, input int want, input logic txr);
        step(1'b1, 1'b0, a, 12'd0, txr, 1'b0, 8'd0, want);
    endtask

    task automatic wr_reg(input logic [8:0] a, input logic [11:0] d, input logic txr);
        step(1'b0, 1'b1, a, d, txr, 1'b0, 8'd0, -1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
        #1 rstn = 1'b0;
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        tx_exp.delete();
        dout_q.delete();
        ovf_m = 1'b0; kfull_m = 1'b0; kbyte_m = '0; ready_ok_m = 1'b0;
        #1 rstn = 1'b1;
        #1;
        check("rx_ready_pre_edge", 32'(rx_ready), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [8:0] ra;
        ovf_m = 1'b0; kfull_m = 1'b0; kbyte_m = '0; ready_ok_m = 1'b0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #2;
        check("reset_tx_valid", 32'(tx_valid), 32'd0);
        check("reset_rx_ready", 32'(rx_ready), 32'd0);
        check("reset_data_out", 32'(data_out), 32'd0);
        #12 rstn = 1'b1;
        #1;
        check("rx_ready_before_first_edge", 32'(rx_ready), 32'd0);

        idle(1'b0);
        idle(1'b0);

        // Fill the screen FIFO, then overflow it with a fifth byte.
        for (int i = 0; i < 4; i++) wr_reg(9'd509, 12'h041 + 12'(i), 1'b0);
        rd_reg(9'd508, 12'h000, 1'b0);
        wr_reg(9'd509, 12'h045, 1'b0);
        rd_reg(9'd508, 12'h002, 1'b0);

        // Drain: 0x41..0x44 on consecutive cycles, then nothing.
        for (int i = 0; i < 5; i++) idle(1'b1);
        check("tx_valid_drained", 32'(tx_valid), 32'd0);
        wr_reg(9'd508, 12'h000, 1'b1);
        rd_reg(9'd508, 12'h001, 1'b1);

        // Full FIFO with a simultaneous pop accepts the write without overflow.
        for (int i = 0; i < 4; i++) wr_reg(9'd509, 12'h051 + 12'(i), 1'b0);
        wr_reg(9'd509, 12'h055, 1'b1);
        rd_reg(9'd508, 12'h000, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        check("tx_valid_drained2", 32'(tx_valid), 32'd0);

        // Keyboard capture, status, read-to-clear, and re-read of the last byte.
        step(1'b0, 1'b0, 9'd0, 12'd0, 1'b0, 1'b1, 8'h7A, -1);
        rd_reg(9'd510, 12'h001, 1'b0);
        check("rx_ready_full", 32'(rx_ready), 32'd0);
        rd_reg(9'd511, 12'h07A, 1'b0);
        rd_reg(9'd510, 12'h000, 1'b0);
        check("rx_ready_cleared", 32'(rx_ready), 32'd1);
        rd_reg(9'd511, 12'h07A, 1'b0);
        rd_reg(9'd510, 12'h000, 1'b0);

        // Undecoded reads and writes to read-only registers.
        rd_reg(9'd100, 12'h000, 1'b0);
        wr_reg(9'd510, 12'hFFF, 1'b0);
        wr_reg(9'd511, 12'hFFF, 1'b0);
        rd_reg(9'd510, 12'h000, 1'b0);
        rd_reg(9'd511, 12'h07A, 1'b0);
        step(1'b1, 1'b1, 9'd509, 12'h066, 1'b0, 1'b0, 8'd0, 12'h000);
        rd_reg(9'd508, 12'h001, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    ra = 9'd509;
                2:       ra = 9'd508;
                3:       ra = 9'd510;
                4:       ra = 9'd511;
                default: ra = 9'($urandom);
            endcase
            step(1'($urandom), ($urandom_range(0, 2) == 0), ra, 12'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 8'($urandom), -1);
        end
        for (int i = 0; i < TXDEPTH + 2; i++) idle(1'b1);
        check("tx_valid_after_random", 32'(tx_valid), 32'd0);
        rd_reg(9'd511, -1, 1'b0);

        // Reset mid-transfer discards queued bytes and the keyboard byte.
        wr_reg(9'd509, 12'h0A1, 1'b0);
        wr_reg(9'd509, 12'h0A2, 1'b0);
        step(1'b0, 1'b0, 9'd0, 12'd0, 1'b0, 1'b1, 8'h3C, -1);
        idle(1'b0);
        pulse_reset();
        rd_reg(9'd508, 12'h001, 1'b0);
        rd_reg(9'd510, 12'h000, 1'b0);
        rd_reg(9'd511, 12'h000, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("tx_valid_after_reset", 32'(tx_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
